div_seq: RTL
============

// Module: div_seq
// PURPOSE
//   Iterative radix-2 restoring divider plus its sequencer for the EX-stage HI/LO unit.
//   Accepts one DIV/DIVU from EX, holds EX stalled while iterating, then presents
//   quotient (LO) and remainder (HI) for exactly the cycle(s) EX may advance.
//   Sits beside the ALU; its stall_o is ORed into the hazard unit's stallE/stallF/stallD.
// PARAMETERS
//   WIDTH   32   operand/result width; iteration count = WIDTH
// PORTS
//   clk       in   1      clock, rising edge
//   rst       in   1      asynchronous, active-low reset
//   start_i   in   1      divide request from EX (isdivE); sampled only in IDLE
//   signed_i  in   1      1 = DIV (two's complement), 0 = DIVU; sampled with start_i
//   a_i       in   WIDTH  dividend; sampled with start_i
//   b_i       in   WIDTH  divisor; sampled with start_i
//   cancel_i  in   1      flushE/exception: abort current operation
//   hold_i    in   1      pipeline held by another cause; keeps result presented
//   stall_o   out  1      1 = EX must not advance
//   valid_o   out  1      result valid; EX writes HI/LO on this cycle when ~hold_i
//   lo_o      out  WIDTH  quotient
//   hi_o      out  WIDTH  remainder
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, counter=0, stall_o=0, valid_o=0, lo_o=0, hi_o=0.
//   States: IDLE, BUSY, DONE.
//   IDLE: stall_o = start_i & ~cancel_i (combinational, same cycle as request).
//     start_i & ~cancel_i: latch |a|,|b| (abs only when signed_i), sign flags;
//       b_i==0 -> DONE directly (div-by-zero, 1-cycle path); else -> BUSY, counter=0.
//   BUSY: one quotient bit per cycle, MSB first; partial remainder WIDTH+1 bits,
//     subtract |b|, keep if non-negative (quotient bit 1), else restore (bit 0).
//     stall_o=1. counter==WIDTH-1 -> DONE. Latency start->valid_o = WIDTH+1 cycles.
//   DONE: valid_o=1, stall_o=0, lo_o/hi_o driven from registers.
//     ~hold_i -> IDLE next cycle; hold_i -> stay in DONE, outputs unchanged.
//     start_i in DONE is ignored (it is the same instruction still in EX).
//   Sign fix-up (signed_i): quotient negated if sign(a)!=sign(b); remainder takes
//     sign of dividend. Arithmetic mod 2^WIDTH: 0x80000000 / 0xFFFFFFFF ->
//     lo=0x80000000, hi=0 (no trap).
//   Divide-by-zero: lo = all ones, hi = a_i (as sampled), no exception.
//   cancel_i: in any state -> IDLE next edge, valid_o=0 that next cycle,
//     stall_o=0 in the cancel cycle; outputs lo_o/hi_o hold last values.
//     cancel_i & start_i same cycle in IDLE: cancel wins, no operation starts.
//   Reset mid-operation: immediate return to reset values; no partial result exposed.
//   valid_o and stall_o are never both 1.
// CONFIGURATION
//   DIV_EARLY_EXIT_EN defined: in IDLE, if |a| < |b| (unsigned compare of magnitudes,
//     b!=0) go straight to DONE with lo=0, hi=a_i; latency 1 cycle, same as div-by-0.
//   Not defined: every non-zero-divisor op takes full WIDTH+1 cycles.
// TESTING
//   DIVU a=100,b=7 -> stall_o high 33 cycles, valid_o at +33, lo=14, hi=2.
//   DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//   DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; b=0, a=5 -> lo=0xFFFFFFFF, hi=5 at +1.
//   start, cancel_i at BUSY cycle 10 -> IDLE next edge, valid_o never 1, stall_o=0 after;
//     new DIVU 9/3 immediately after -> lo=3, hi=0.
//   result with hold_i=1 for 4 cycles -> valid_o stays 1, lo/hi stable, IDLE after release.
//   DIV_EARLY_EXIT_EN: DIVU 3/10 -> valid_o at +1, lo=0, hi=3; without macro at +33.

Source files
------------

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider and sequencer for the EX-stage HI/LO unit.
// Optional build macro DIV_EARLY_EXIT_EN: finish in one cycle when |a| < |b|.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    input  logic             hold_i,
    output logic             stall_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state, w_next;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_negQ;
    logic             r_negR;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;

    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic             w_bZero;
    logic             w_early;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic             w_qbit;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_qFinal;
    logic [WIDTH-1:0] w_loFix;
    logic [WIDTH-1:0] w_hiFix;

    assign w_absA   = (signed_i && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
    assign w_absB   = (signed_i && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;
    assign w_bZero  = (b_i == '0);
    assign w_accept = start_i && !cancel_i;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

`ifdef DIV_EARLY_EXIT_EN
    assign w_early = (w_absA < w_absB);
`else
    assign w_early = 1'b0;
`endif

    // The shifted partial remainder is WIDTH+1 bits; since it stays below 2*|b|,
    // the low WIDTH bits of the difference are exact whenever the bit is kept.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_qbit    = (w_shift >= {1'b0, r_b});
    assign w_sub     = w_shift[WIDTH-1:0] - r_b;
    assign w_remNext = w_qbit ? w_sub : w_shift[WIDTH-1:0];
    assign w_qFinal  = {r_quo[WIDTH-2:0], w_qbit};
    assign w_loFix   = r_negQ ? (~w_qFinal + 1'b1) : w_qFinal;
    assign w_hiFix   = r_negR ? (~w_remNext + 1'b1) : w_remNext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        stall_o = 1'b0;
        valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    stall_o = 1'b1;
                    w_next  = (w_bZero || w_early) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cancel_i) begin
                    w_next = IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (w_last) begin
                        w_next = DONE;
                    end
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (cancel_i || !hold_i) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Result registers only change when an operation completes, so a cancel
    // leaves the previous HI/LO visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_negQ <= 1'b0;
            r_negR <= 1'b0;
            r_lo   <= '0;
            r_hi   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rem  <= '0;
                        r_quo  <= w_absA;
                        r_b    <= w_absB;
                        r_cnt  <= '0;
                        r_negQ <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        r_negR <= signed_i && a_i[WIDTH-1];
                        if (w_bZero) begin
                            r_lo <= '1;
                            r_hi <= a_i;
                        end else if (w_early) begin
                            r_lo <= '0;
                            r_hi <= a_i;
                        end
                    end
                end
                BUSY: begin
                    if (!cancel_i) begin
                        r_rem <= w_remNext;
                        r_quo <= w_qFinal;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_lo <= w_loFix;
                            r_hi <= w_hiFix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign lo_o = r_lo;
    assign hi_o = r_hi;

endmodule
